// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : Iterative signed multiply / divide unit owning the HI/LO
//                registers. Shift-add multiply (LSB first) and restoring
//                divide (MSB first) on operand magnitudes, sign-corrected in a
//                final cycle. Fixed latency of WIDTH+1 cycles per operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0]       c_OP_MULT  = 4'b0101;
    localparam logic [3:0]       c_OP_DIV   = 4'b1011;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_CALC   = 2'd1;
    localparam logic [1:0] c_ST_FINISH = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_sa;
    logic               r_sb;
    logic [WIDTH-1:0]   r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_valid_op;
    logic               w_accept;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_diff;
    logic [2*WIDTH-1:0] w_div_nxt;
    logic [2*WIDTH-1:0] w_prod_signed;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_valid_op = (alu_ctrl == c_OP_MULT) || (alu_ctrl == c_OP_DIV);
    assign w_accept   = (r_state == c_ST_IDLE) && start && w_valid_op;

    // Magnitudes are unsigned, so the most negative value maps onto itself.
    assign w_abs_a = src_a[WIDTH-1] ? ((~src_a) + WIDTH'(1)) : src_a;
    assign w_abs_b = src_b[WIDTH-1] ? ((~src_b) + WIDTH'(1)) : src_b;

    // Multiply: accumulator is {partial product, remaining multiplier bits}.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_mag_a} : {(WIDTH+1){1'b0}});
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: accumulator is {partial remainder, dividend / quotient bits}.
    // The remainder stays below the divisor, so a W-bit difference suffices.
    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge   = (w_rem_sh >= {1'b0, r_mag_b});
    assign w_div_diff = w_rem_sh[WIDTH-1:0] - r_mag_b;
    assign w_div_nxt  = {(w_div_ge ? w_div_diff : w_rem_sh[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_div_ge};

    assign w_prod_signed = (r_sa ^ r_sb) ? ((~r_acc) + (2*WIDTH)'(1)) : r_acc;

    always_comb begin
        w_res_hi = w_prod_signed[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod_signed[WIDTH-1:0];
        if (r_is_div) begin
            // A zero divisor leaves the dividend magnitude in the remainder,
            // so restoring its sign reproduces src_a in HI.
            w_res_hi = r_sa ? ((~r_acc[2*WIDTH-1:WIDTH]) + WIDTH'(1))
                            : r_acc[2*WIDTH-1:WIDTH];
            if (r_mag_b == '0) begin
                w_res_lo = '1;
            end else if (r_sa ^ r_sb) begin
                w_res_lo = (~r_acc[WIDTH-1:0]) + WIDTH'(1);
            end else begin
                w_res_lo = r_acc[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_accept) w_state_nxt = c_ST_CALC;
            c_ST_CALC:   if (r_cnt == c_CNT_LAST) w_state_nxt = c_ST_FINISH;
            c_ST_FINISH: w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_is_div <= (alu_ctrl == c_OP_DIV);
                        r_sa     <= src_a[WIDTH-1];
                        r_sb     <= src_b[WIDTH-1];
                        r_mag_a  <= w_abs_a;
                        r_mag_b  <= w_abs_b;
                        r_acc    <= {{WIDTH{1'b0}},
                                     ((alu_ctrl == c_OP_DIV) ? w_abs_a : w_abs_b)};
                        r_cnt    <= '0;
                    end
                end
                c_ST_CALC: begin
                    r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                c_ST_FINISH: begin
                    r_hi   <= w_res_hi;
                    r_lo   <= w_res_lo;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != c_ST_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_sequencer
//  Description : Scoreboard bench for muldiv_sequencer against a signed
//                64-bit arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam int         WIDTH     = 32;
    localparam logic [3:0] c_OP_MULT = 4'b0101;
    localparam logic [3:0] c_OP_DIV  = 4'b1011;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic [3:0]  alu_ctrl = 4'b0000;
    logic [31:0] src_a    = '0;
    logic [31:0] src_b    = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [31:0] hold_hi = '0;
    logic [31:0] hold_lo = '0;

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .alu_ctrl (alu_ctrl),
        .src_a    (src_a),
        .src_b    (src_b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        longint la;
        longint lb;
        logic [63:0] p;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (ctrl == c_OP_MULT) begin
            p = la * lb;
            r.hi = p[63:32];
            r.lo = p[31:0];
        end else if (lb == 0) begin
            r.lo = '1;
            r.hi = a;
        end else begin
            p = la / lb;
            r.lo = p[31:0];
            p = la % lb;
            r.hi = p[31:0];
        end
        return r;
    endfunction

    // Monitor: compares results on done, otherwise HI/LO must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_hi = '0;
            hold_lo = '0;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: hi=%h lo=%h with no pending op", hi, lo);
            end else begin
                mon_e = exp_q.pop_front();
                check32("result_hi", hi, mon_e.hi);
                check32("result_lo", lo, mon_e.lo);
                hold_hi = mon_e.hi;
                hold_lo = mon_e.lo;
            end
        end else begin
            check32("hold_hi", hi, hold_hi);
            check32("hold_lo", lo, hold_lo);
        end
    end

    // Issues one op at #1 after an edge and follows it to its done cycle.
    // inject_at > 0 presents a stray valid start just before that edge.
    task automatic issue(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, input int inject_at);
        int bad = 0;
        start = 1'b1; alu_ctrl = ctrl; src_a = a; src_b = b;
        @(posedge clk); #1;
        exp_q.push_back(e);
        start = 1'b0; src_a = $urandom; src_b = $urandom; alu_ctrl = 4'($urandom);
        if (busy !== 1'b1 || done !== 1'b0) bad++;
        for (int k = 1; k <= WIDTH + 1; k++) begin
            if (k == inject_at) begin
                start = 1'b1; alu_ctrl = c_OP_MULT; src_a = $urandom; src_b = $urandom;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (k <= WIDTH) begin
                if (busy !== 1'b1 || done !== 1'b0) bad++;
            end
        end
        check32("busy_window_errors", 32'(bad), 32'd0);
        check32("done_at_E33", {31'd0, done}, 32'd1);
        check32("busy_low_at_E33", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_model(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                             input int inject_at);
        issue(ctrl, a, b, model(ctrl, a, b), inject_at);
    endtask

    task automatic run_exp(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo, input int inject_at);
        exp_t e;
        e.hi = ehi;
        e.lo = elo;
        issue(ctrl, a, b, e, inject_at);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials[5];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        if ($urandom_range(0, 1) == 0) return 32'($signed(16'($urandom)));
        return $urandom;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ctrl;
        repeat (3) @(posedge clk);
        #1;
        check32("reset_busy", {31'd0, busy}, 32'd0);
        check32("reset_done", {31'd0, done}, 32'd0);
        check32("reset_hi", hi, 32'd0);
        check32("reset_lo", lo, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases, back-to-back; a stray start lands at E5 of the first.
        run_exp(c_OP_MULT, 32'd7,          32'd6,          32'h0000_0000, 32'h0000_002A, 5);
        run_exp(c_OP_MULT, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
        run_exp(c_OP_MULT, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 0);
        run_exp(c_OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_exp(c_OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, 0);
        run_exp(c_OP_DIV,  32'h1234_5678,  32'd0,          32'h1234_5678, 32'hFFFF_FFFF, 0);
        run_exp(c_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 0);

        // Invalid code in IDLE is ignored.
        @(posedge clk); #1;
        start = 1'b1; alu_ctrl = 4'b0010; src_a = 32'd9; src_b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        check32("invalid_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check32("invalid_done", {31'd0, done}, 32'd0);
        check32("invalid_busy_later", {31'd0, busy}, 32'd0);

        // Reset in the middle of a divide discards it.
        start = 1'b1; alu_ctrl = c_OP_DIV; src_a = 32'd1000; src_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check32("midreset_busy", {31'd0, busy}, 32'd0);
        check32("midreset_done", {31'd0, done}, 32'd0);
        check32("midreset_hi", hi, 32'd0);
        check32("midreset_lo", lo, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_exp(c_OP_MULT, 32'd2, 32'd3, 32'h0000_0000, 32'h0000_0006, 0);

        // Randomized ops with random gaps and occasional stray starts.
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            if (i % 2 == 0) begin
                ctrl = c_OP_DIV;
            end else begin
                ctrl = c_OP_MULT;
            end
            if ($urandom_range(0, 2) == 0) ctrl = ($urandom_range(0, 1) == 1) ? c_OP_DIV : c_OP_MULT;
            run_model(ctrl, pick_operand(), pick_operand(),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, WIDTH)) : 0);
        end

        repeat (5) @(posedge clk);
        #1;
        check32("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
